// File: rtl/lattice_bram_arbiter_if.sv
// Requester, read-return and BRAM-side signals of the lattice BRAM arbiter.
interface lattice_bram_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic                   comp_req_in;
  logic                   comp_we_in;
  logic [8:0][ADDR_W-1:0] comp_addr_in;
  logic [8:0][7:0]        comp_data_in;
  logic                   comp_grant_out;
  logic                   comp_rvalid_out;
  logic [8:0][7:0]        comp_rdata_out;
  logic                   disp_req_in;
  logic [ADDR_W-1:0]      disp_addr_in;
  logic                   disp_grant_out;
  logic                   disp_rvalid_out;
  logic [8:0][7:0]        disp_rdata_out;
  logic [8:0][ADDR_W-1:0] bram_addr_out;
  logic                   bram_we_out;
  logic [8:0][7:0]        bram_wdata_out;
  logic [8:0][7:0]        bram_rdata_in;
  logic                   err_out;

  modport slave (
    input  comp_req_in, comp_we_in, comp_addr_in, comp_data_in,
    input  disp_req_in, disp_addr_in, bram_rdata_in,
    output comp_grant_out, comp_rvalid_out, comp_rdata_out,
    output disp_grant_out, disp_rvalid_out, disp_rdata_out,
    output bram_addr_out, bram_we_out, bram_wdata_out, err_out
  );

  modport master (
    output comp_req_in, comp_we_in, comp_addr_in, comp_data_in,
    output disp_req_in, disp_addr_in, bram_rdata_in,
    input  comp_grant_out, comp_rvalid_out, comp_rdata_out,
    input  disp_grant_out, disp_rvalid_out, disp_rdata_out,
    input  bram_addr_out, bram_we_out, bram_wdata_out, err_out
  );
endinterface

// File: rtl/lattice_bram_arbiter.sv
// Shares the 9-bank lattice BRAM between the LBM compute engine and the display
// reader; display wins by default, compute is forced through after a bounded wait.
module lattice_bram_arbiter #(
  parameter int HPIXELS       = 320,
  parameter int VPIXELS       = 180,
  parameter int ADDR_W        = $clog2(HPIXELS*VPIXELS),
  parameter int READ_LATENCY  = 2,
  parameter int COMP_MAX_WAIT = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  lattice_bram_arbiter_if.slave bus
);
  localparam int BRAM_DEPTH = HPIXELS*VPIXELS;
  localparam int CNT_W      = $clog2(COMP_MAX_WAIT+1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(COMP_MAX_WAIT);
  // One extra bit so a power-of-two depth does not wrap to zero.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(BRAM_DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  function automatic logic addr_oob(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= DEPTH_EXT;
  endfunction

  function automatic logic [8:0][7:0] mask_rdata(input logic oob, input logic [8:0][7:0] d);
    return oob ? '0 : d;
  endfunction

  logic [CNT_W-1:0]        starve_cnt;
  logic                    force_comp;
  logic                    comp_grant;
  logic                    disp_grant;
  logic                    comp_oob;
  logic                    disp_oob;
  logic [READ_LATENCY-1:0] tag_vld_p;
  logic [READ_LATENCY-1:0] tag_disp_p;
  logic [READ_LATENCY-1:0] tag_oob_p;

  always_comb begin
    force_comp = bus.comp_req_in && (starve_cnt >= CNT_MAX);
    comp_grant = !rst_in && bus.comp_req_in && (force_comp || !bus.disp_req_in);
    disp_grant = !rst_in && bus.disp_req_in && !force_comp;
    comp_oob   = 1'b0;
    for (int i = 0; i < 9; i++) begin
      comp_oob = comp_oob | addr_oob(bus.comp_addr_in[i]);
    end
    disp_oob = addr_oob(bus.disp_addr_in);
  end

  assign bus.comp_grant_out = comp_grant;
  assign bus.disp_grant_out = disp_grant;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      starve_cnt <= '0;
    end else if (!bus.comp_req_in || comp_grant) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Issue stage: register BRAM address/data/we and launch the read tag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.bram_addr_out  <= '0;
      bus.bram_wdata_out <= '0;
      bus.bram_we_out    <= 1'b0;
      bus.err_out        <= 1'b0;
      tag_vld_p          <= '0;
      tag_disp_p         <= '0;
      tag_oob_p          <= '0;
    end else begin
      bus.bram_we_out <= 1'b0;
      tag_vld_p[0]    <= disp_grant || (comp_grant && !bus.comp_we_in);
      tag_disp_p[0]   <= disp_grant;
      tag_oob_p[0]    <= disp_grant ? disp_oob : comp_oob;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld_p[i]  <= tag_vld_p[i-1];
        tag_disp_p[i] <= tag_disp_p[i-1];
        tag_oob_p[i]  <= tag_oob_p[i-1];
      end
      if (disp_grant) begin
        bus.bram_addr_out <= {9{bus.disp_addr_in}};
      end else if (comp_grant) begin
        bus.bram_addr_out  <= bus.comp_addr_in;
        bus.bram_wdata_out <= bus.comp_data_in;
        // An out-of-range write is swallowed and flagged instead of aliasing.
        bus.bram_we_out    <= bus.comp_we_in && !comp_oob;
        if (bus.comp_we_in && comp_oob) begin
          bus.err_out <= 1'b1;
        end
      end
    end
  end

  // Return stage: capture BRAM data for the tag owner at the end of the pipeline.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.comp_rvalid_out <= 1'b0;
      bus.disp_rvalid_out <= 1'b0;
      bus.comp_rdata_out  <= '0;
      bus.disp_rdata_out  <= '0;
    end else begin
      bus.comp_rvalid_out <= tag_vld_p[READ_LATENCY-1] && !tag_disp_p[READ_LATENCY-1];
      bus.disp_rvalid_out <= tag_vld_p[READ_LATENCY-1] && tag_disp_p[READ_LATENCY-1];
      if (tag_vld_p[READ_LATENCY-1] && !tag_disp_p[READ_LATENCY-1]) begin
        bus.comp_rdata_out <= mask_rdata(tag_oob_p[READ_LATENCY-1], bus.bram_rdata_in);
      end
      if (tag_vld_p[READ_LATENCY-1] && tag_disp_p[READ_LATENCY-1]) begin
        bus.disp_rdata_out <= mask_rdata(tag_oob_p[READ_LATENCY-1], bus.bram_rdata_in);
      end
    end
  end
endmodule

// File: tb/tb_lattice_bram_arbiter.sv
// Bench for lattice_bram_arbiter: directed steps plus random traffic against a
// transaction-level model (grant rules, ordered return queue, cell memory).
module tb_lattice_bram_arbiter;
  localparam int HP    = 320;
  localparam int VP    = 180;
  localparam int DEPTH = HP*VP;
  localparam int AW    = $clog2(DEPTH);
  localparam int RL    = 2;
  localparam int MAXW  = 4;
  localparam int LAT   = 1 + RL;

  typedef struct {
    int              due;
    bit              disp;
    logic [8:0][7:0] data;
  } ret_t;

  logic clk;
  logic rst;
  lattice_bram_arbiter_if #(.ADDR_W(AW)) bus ();

  lattice_bram_arbiter #(
    .HPIXELS(HP), .VPIXELS(VP), .ADDR_W(AW),
    .READ_LATENCY(RL), .COMP_MAX_WAIT(MAXW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a, input int i);
    return 8'((a - 100) * 13 + i + 1);
  endfunction

  // Write-first synchronous BRAM; with the arbiter's capture register this gives RL total.
  bit   [8:0]      wr_flag [DEPTH];
  logic [8:0][7:0] wr_mem  [DEPTH];
  always @(posedge clk) begin
    for (int i = 0; i < 9; i++) begin
      if (int'(bus.bram_addr_out[i]) < DEPTH) begin
        if (bus.bram_we_out) begin
          wr_mem[bus.bram_addr_out[i]][i]  <= bus.bram_wdata_out[i];
          wr_flag[bus.bram_addr_out[i]][i] <= 1'b1;
          bus.bram_rdata_in[i]             <= bus.bram_wdata_out[i];
        end else begin
          bus.bram_rdata_in[i] <= wr_flag[bus.bram_addr_out[i]][i] ?
                                  wr_mem[bus.bram_addr_out[i]][i] :
                                  init_val(int'(bus.bram_addr_out[i]), i);
        end
      end else begin
        bus.bram_rdata_in[i] <= 8'hA5;
      end
    end
  end

  // Reference model state
  logic [8:0][7:0]    ref_mem [DEPTH];
  ret_t               q[$];
  int                 starve;
  int                 cyc;
  logic               exp_we, exp_err;
  logic [8:0][AW-1:0] exp_addr;
  logic [8:0][7:0]    exp_wdata, exp_crd, exp_drd;

  logic               obs_cg, obs_dg, obs_cv, obs_dv, obs_we, obs_err;
  logic [8:0][7:0]    obs_crd, obs_drd;
  logic [8:0][AW-1:0] obs_addr;

  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    ret_t            e;
    logic            ecv, edv, gc, gd, oob;
    logic [8:0][7:0] rd;
    @(negedge clk);
    ecv = 1'b0;
    edv = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.disp) begin
        edv = 1'b1;
        exp_drd = e.data;
      end else begin
        ecv = 1'b1;
        exp_crd = e.data;
      end
    end
    obs_cg = bus.comp_grant_out;   obs_dg  = bus.disp_grant_out;
    obs_cv = bus.comp_rvalid_out;  obs_dv  = bus.disp_rvalid_out;
    obs_crd = bus.comp_rdata_out;  obs_drd = bus.disp_rdata_out;
    obs_we = bus.bram_we_out;      obs_err = bus.err_out;
    obs_addr = bus.bram_addr_out;
    chk("comp_rvalid", 144'(obs_cv), 144'(ecv));
    chk("disp_rvalid", 144'(obs_dv), 144'(edv));
    chk("comp_rdata", 144'(obs_crd), 144'(exp_crd));
    chk("disp_rdata", 144'(obs_drd), 144'(exp_drd));
    chk("bram_we", 144'(obs_we), 144'(exp_we));
    chk("bram_addr", 144'(obs_addr), 144'(exp_addr));
    chk("bram_wdata", 144'(bus.bram_wdata_out), 144'(exp_wdata));
    chk("err", 144'(obs_err), 144'(exp_err));

    gc = 1'b0;
    gd = 1'b0;
    if (!rst) begin
      if (bus.comp_req_in && starve >= MAXW) gc = 1'b1;
      else if (bus.disp_req_in)              gd = 1'b1;
      else if (bus.comp_req_in)              gc = 1'b1;
    end
    chk("comp_grant", 144'(obs_cg), 144'(gc));
    chk("disp_grant", 144'(obs_dg), 144'(gd));

    exp_we = 1'b0;
    if (rst) begin
      q.delete();
      starve = 0;
      exp_addr = '0; exp_wdata = '0; exp_err = 1'b0;
      exp_crd = '0;  exp_drd = '0;
    end else begin
      starve = (bus.comp_req_in && !gc) ? ((starve + 1 > MAXW) ? MAXW : starve + 1) : 0;
      if (gd) begin
        exp_addr = {9{bus.disp_addr_in}};
        oob = int'(bus.disp_addr_in) >= DEPTH;
        for (int i = 0; i < 9; i++) rd[i] = oob ? 8'h00 : ref_mem[bus.disp_addr_in][i];
        q.push_back('{due: cyc + LAT, disp: 1'b1, data: rd});
      end
      if (gc) begin
        exp_addr  = bus.comp_addr_in;
        exp_wdata = bus.comp_data_in;
        oob = 1'b0;
        for (int i = 0; i < 9; i++) if (int'(bus.comp_addr_in[i]) >= DEPTH) oob = 1'b1;
        if (bus.comp_we_in) begin
          if (oob) exp_err = 1'b1;
          else begin
            exp_we = 1'b1;
            for (int i = 0; i < 9; i++) ref_mem[bus.comp_addr_in[i]][i] = bus.comp_data_in[i];
          end
        end else begin
          for (int i = 0; i < 9; i++) rd[i] = oob ? 8'h00 : ref_mem[bus.comp_addr_in[i]][i];
          q.push_back('{due: cyc + LAT, disp: 1'b0, data: rd});
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 127) == 0) return AW'(DEPTH + $urandom_range(0, 5));
    return AW'($urandom_range(0, 15));
  endfunction

  task automatic rand_comp();
    bus.comp_req_in = ($urandom_range(0, 2) != 0);
    bus.comp_we_in  = 1'($urandom_range(0, 1));
    for (int i = 0; i < 9; i++) begin
      bus.comp_addr_in[i] = rand_addr();
      bus.comp_data_in[i] = 8'($urandom());
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    starve = 0;
    for (int a = 0; a < DEPTH; a++)
      for (int i = 0; i < 9; i++) ref_mem[a][i] = init_val(a, i);
    exp_we = 1'b0; exp_err = 1'b0; exp_addr = '0; exp_wdata = '0;
    exp_crd = '0;  exp_drd = '0;
    rst = 1'b1;
    bus.comp_req_in = 1'b0; bus.comp_we_in = 1'b0;
    bus.comp_addr_in = '0;  bus.comp_data_in = '0;
    bus.disp_req_in = 1'b0; bus.disp_addr_in = '0;

    // Reset held three cycles from power-up
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Single display read of cell 100
    bus.disp_req_in = 1'b1;
    bus.disp_addr_in = AW'(100);
    tick();
    chk("disp_grant_100", 144'(obs_dg), 144'(1));
    bus.disp_req_in = 1'b0;
    tick();
    chk("disp_addr_100", 144'(obs_addr), 144'({9{16'd100}}));
    tick();
    tick();
    chk("disp_rvalid_100", 144'(obs_dv), 144'(1));
    chk("disp_rdata_100", 144'(obs_drd), 144'(72'h090807060504030201));
    chk("comp_rvalid_100", 144'(obs_cv), 144'(0));

    // Both requesting continuously: compute forced in every fifth cycle
    bus.comp_req_in = 1'b1;
    bus.comp_we_in  = 1'b0;
    for (int i = 0; i < 9; i++) bus.comp_addr_in[i] = AW'(20 + i);
    bus.disp_req_in = 1'b1;
    bus.disp_addr_in = AW'(7);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("starve_comp", 144'(obs_cg), 144'(k == 4 || k == 9));
      chk("starve_disp", 144'(obs_dg), 144'(!(k == 4 || k == 9)));
    end
    bus.comp_req_in = 1'b0;
    bus.disp_req_in = 1'b0;
    repeat (4) tick();

    // Compute write to cell 5 followed by a read of it
    bus.comp_req_in = 1'b1;
    bus.comp_we_in  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.comp_addr_in[i] = AW'(5);
      bus.comp_data_in[i] = 8'((i + 1) * 8'h11);
    end
    tick();
    chk("wr_grant", 144'(obs_cg), 144'(1));
    bus.comp_we_in = 1'b0;
    tick();
    chk("wr_we_pulse", 144'(obs_we), 144'(1));
    bus.comp_req_in = 1'b0;
    tick();
    chk("wr_we_end", 144'(obs_we), 144'(0));
    tick();
    tick();
    chk("raw_rvalid", 144'(obs_cv), 144'(1));
    chk("raw_rdata", 144'(obs_crd), 144'(72'h998877665544332211));

    // Out-of-range write on lane 3, then out-of-range display read
    bus.comp_req_in = 1'b1;
    bus.comp_we_in  = 1'b1;
    bus.comp_addr_in = '0;
    bus.comp_addr_in[3] = AW'(DEPTH);
    tick();
    chk("oob_wr_grant", 144'(obs_cg), 144'(1));
    bus.comp_req_in = 1'b0;
    tick();
    chk("oob_wr_we", 144'(obs_we), 144'(0));
    chk("oob_err_set", 144'(obs_err), 144'(1));
    bus.disp_req_in = 1'b1;
    bus.disp_addr_in = AW'(DEPTH + 2);
    tick();
    bus.disp_req_in = 1'b0;
    tick();
    tick();
    tick();
    chk("oob_rd_rvalid", 144'(obs_dv), 144'(1));
    chk("oob_rd_zero", 144'(obs_drd), 144'(0));

    // Interleaved display/compute reads
    for (int k = 0; k < 20; k++) begin
      bus.disp_req_in = (k % 2 == 0);
      bus.comp_req_in = (k % 2 == 1);
      bus.comp_we_in  = 1'b0;
      bus.disp_addr_in = AW'($urandom_range(0, 15));
      for (int i = 0; i < 9; i++) bus.comp_addr_in[i] = AW'($urandom_range(0, 15));
      tick();
    end
    bus.disp_req_in = 1'b0;
    bus.comp_req_in = 1'b0;
    repeat (4) tick();
    chk("err_sticky", 144'(obs_err), 144'(1));

    // Random traffic; a requester changes its fields only once granted or idle
    for (int k = 0; k < 300; k++) begin
      if (!bus.comp_req_in || obs_cg) rand_comp();
      if (!bus.disp_req_in || obs_dg) begin
        bus.disp_req_in = ($urandom_range(0, 1) != 0);
        bus.disp_addr_in = rand_addr();
      end
      tick();
    end
    bus.comp_req_in = 1'b0;
    bus.disp_req_in = 1'b0;
    repeat (4) tick();

    // Reset asserted with three reads in flight
    bus.disp_req_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus.disp_addr_in = AW'(k);
      tick();
    end
    bus.disp_req_in = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_rvalid", 144'(obs_cv | obs_dv), 144'(0));
    end
    chk("post_rst_err", 144'(obs_err), 144'(0));
    chk("post_rst_we", 144'(obs_we), 144'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
